// File: rtl/snake_pkg.sv
// Shared types, default tick constants and direction helpers for the snake step sequencer.
package snake_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      OVER  = 2'd3
   } game_state_t;

   // Encoding doubles as the bit index of the one-hot L/U/D/R command.
   typedef enum logic [1:0] {
      DIR_L = 2'd0,
      DIR_U = 2'd1,
      DIR_D = 2'd2,
      DIR_R = 2'd3
   } dir_t;

   localparam int DEF_TICK_BASE        = 12_500_000;
   localparam int DEF_TICK_STEP        = 1_000_000;
   localparam int DEF_TICK_MIN         = 2_500_000;
   localparam int DEF_APPLES_PER_LEVEL = 4;

   function automatic logic is_reverse(input dir_t a, input dir_t b);
      logic rev;
      case (a)
         DIR_L:   rev = (b == DIR_R);
         DIR_R:   rev = (b == DIR_L);
         DIR_U:   rev = (b == DIR_D);
         DIR_D:   rev = (b == DIR_U);
         default: rev = 1'b0;
      endcase
      return rev;
   endfunction

   function automatic logic [3:0] dir_onehot(input dir_t d);
      return 4'b0001 << d;
   endfunction

endpackage

// File: rtl/snake_dir_arbiter.sv
// Captures one perpendicular direction per game step and holds it until the step strobe.
module snake_dir_arbiter
   import snake_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       run_en,
   input  logic       sys,
   input  logic       btn_l,
   input  logic       btn_u,
   input  logic       btn_d,
   input  logic       btn_r,
   output logic [3:0] cmd
);

   dir_t       heading_r;
   dir_t       pend_dir_r;
   logic [3:0] cmd_r;
   dir_t       sel_dir_s;
   logic       sel_vld_s;
   logic       accept_s;

   // Fixed priority U > D > L > R among buttons seen in the same cycle.
   always_comb begin
      sel_vld_s = 1'b1;
      sel_dir_s = DIR_L;
      if (btn_u) begin
         sel_dir_s = DIR_U;
      end else if (btn_d) begin
         sel_dir_s = DIR_D;
      end else if (btn_l) begin
         sel_dir_s = DIR_L;
      end else if (btn_r) begin
         sel_dir_s = DIR_R;
      end else begin
         sel_vld_s = 1'b0;
      end
   end

   // A winner on the heading's own axis (same or reverse) is dropped, not replaced.
   always_comb begin
      accept_s = sel_vld_s & (sel_dir_s != heading_r) & ~is_reverse(sel_dir_s, heading_r);
   end

   // Pending command and heading; the step strobe commits and empties the slot.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         heading_r  <= DIR_L;
         pend_dir_r <= DIR_L;
         cmd_r      <= 4'b0000;
      end else if (run_en) begin
         if (sys) begin
            if (cmd_r != 4'b0000) heading_r <= pend_dir_r;
            cmd_r <= 4'b0000;
         end else if ((cmd_r == 4'b0000) && accept_s) begin
            cmd_r      <= dir_onehot(sel_dir_s);
            pend_dir_r <= sel_dir_s;
         end
      end
   end

   assign cmd = cmd_r;

endmodule

// File: rtl/snake_step_sequencer.sv
// Game flow, step-tick generation, score and speed levels for the snake head datapath.
// Optional PAUSE state enabled by defining SNAKE_PAUSE_EN.
module snake_step_sequencer
   import snake_pkg::*;
#(
   parameter int TICK_BASE        = DEF_TICK_BASE,
   parameter int TICK_STEP        = DEF_TICK_STEP,
   parameter int TICK_MIN         = DEF_TICK_MIN,
   parameter int APPLES_PER_LEVEL = DEF_APPLES_PER_LEVEL,
   parameter int SCORE_W          = 8,
   parameter int CNT_W            = 24
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               btn_l,
   input  logic               btn_u,
   input  logic               btn_d,
   input  logic               btn_r,
   input  logic               eaten,
   input  logic               game_over,
   output logic               sys,
   output logic               L,
   output logic               U,
   output logic               D,
   output logic               R,
   output logic               game_rst,
   output logic [SCORE_W-1:0] score,
   output logic [3:0]         level,
   output logic               running
);

   localparam int                 AW          = (APPLES_PER_LEVEL > 1) ? $clog2(APPLES_PER_LEVEL) : 1;
   localparam logic [AW-1:0]      APPLE_LAST  = AW'(APPLES_PER_LEVEL - 1);
   localparam logic [AW-1:0]      APPLE_ONE   = AW'(1);
   localparam logic [CNT_W-1:0]   PERIOD_BASE = CNT_W'(TICK_BASE);
   localparam logic [CNT_W-1:0]   PERIOD_MIN  = CNT_W'(TICK_MIN);
   localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W:0]     STEP_W      = (CNT_W + 1)'(TICK_STEP);
   localparam logic [SCORE_W-1:0] SCORE_ONE   = SCORE_W'(1);

   game_state_t        state_r;
   logic               start_d_r;
   logic               game_rst_r;
   logic               first_run_r;
   logic               running_r;
   logic [CNT_W-1:0]   tick_r;
   logic [CNT_W-1:0]   period_r;
   logic [CNT_W-1:0]   next_period_r;
   logic [AW-1:0]      apple_r;
   logic [SCORE_W-1:0] score_r;
   logic [3:0]         level_r;

   logic               start_rise_s;
   logic               go_s;
   logic               pause_req_s;
   logic               active_s;
   logic               sys_s;
   logic               eaten_s;
   logic               levelup_s;
   logic               arb_clr_s;
   logic [CNT_W:0]     dec_s;
   logic [CNT_W-1:0]   np_s;
   logic [3:0]         cmd_s;

   // game_over is masked on the first RUN cycle so the head has time to leave its reset.
   always_comb begin
      start_rise_s = start & ~start_d_r;
      go_s         = game_over & ~first_run_r;
`ifdef SNAKE_PAUSE_EN
      pause_req_s  = start_rise_s;
`else
      pause_req_s  = 1'b0;
`endif
      active_s     = (state_r == RUN) & ~go_s & ~pause_req_s;
      sys_s        = active_s & (tick_r == (period_r - CNT_ONE));
      eaten_s      = eaten & (state_r == RUN);
      levelup_s    = eaten_s & (apple_r == APPLE_LAST);
      arb_clr_s    = (((state_r == IDLE) | (state_r == OVER)) & start_rise_s & ~game_rst_r)
                   | (((state_r == RUN) | (state_r == PAUSE)) & go_s);
   end

   // Speed-up target, one bit wider so an underflow is caught before the floor.
   always_comb begin
      dec_s = {1'b0, next_period_r} - STEP_W;
      if (!levelup_s) begin
         np_s = next_period_r;
      end else if (dec_s[CNT_W] || (dec_s[CNT_W-1:0] < PERIOD_MIN)) begin
         np_s = PERIOD_MIN;
      end else begin
         np_s = dec_s[CNT_W-1:0];
      end
   end

   // Game-flow FSM with tick counter, score and level.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= IDLE;
         start_d_r     <= 1'b1;
         game_rst_r    <= 1'b0;
         first_run_r   <= 1'b0;
         running_r     <= 1'b0;
         tick_r        <= {CNT_W{1'b0}};
         period_r      <= PERIOD_BASE;
         next_period_r <= PERIOD_BASE;
         apple_r       <= {AW{1'b0}};
         score_r       <= {SCORE_W{1'b0}};
         level_r       <= 4'd0;
      end else begin
         start_d_r   <= start;
         game_rst_r  <= 1'b0;
         first_run_r <= 1'b0;
         if (eaten_s) begin
            if (!(&score_r)) score_r <= score_r + SCORE_ONE;
            if (levelup_s) begin
               apple_r <= {AW{1'b0}};
               if (level_r != 4'hF) level_r <= level_r + 4'd1;
            end else begin
               apple_r <= apple_r + APPLE_ONE;
            end
            next_period_r <= np_s;
         end
         case (state_r)
            IDLE, OVER: begin
               if (game_rst_r) begin
                  state_r     <= RUN;
                  running_r   <= 1'b1;
                  first_run_r <= 1'b1;
                  tick_r      <= {CNT_W{1'b0}};
               end else if (start_rise_s) begin
                  game_rst_r    <= 1'b1;
                  score_r       <= {SCORE_W{1'b0}};
                  level_r       <= 4'd0;
                  apple_r       <= {AW{1'b0}};
                  period_r      <= PERIOD_BASE;
                  next_period_r <= PERIOD_BASE;
               end
            end
            RUN: begin
               if (go_s) begin
                  state_r   <= OVER;
                  running_r <= 1'b0;
               end else if (pause_req_s) begin
                  state_r   <= PAUSE;
                  running_r <= 1'b0;
               end else if (sys_s) begin
                  tick_r   <= {CNT_W{1'b0}};
                  period_r <= np_s;
               end else begin
                  tick_r <= tick_r + CNT_ONE;
               end
            end
`ifdef SNAKE_PAUSE_EN
            PAUSE: begin
               if (go_s) begin
                  state_r <= OVER;
               end else if (start_rise_s) begin
                  state_r   <= RUN;
                  running_r <= 1'b1;
               end
            end
`endif
            default: begin
               state_r   <= IDLE;
               running_r <= 1'b0;
            end
         endcase
      end
   end

   snake_dir_arbiter u_dir_arbiter (
      .clk    (clk),
      .reset  (reset),
      .clr    (arb_clr_s),
      .run_en (active_s),
      .sys    (sys_s),
      .btn_l  (btn_l),
      .btn_u  (btn_u),
      .btn_d  (btn_d),
      .btn_r  (btn_r),
      .cmd    (cmd_s)
   );

   assign sys      = sys_s;
   assign L        = cmd_s[0];
   assign U        = cmd_s[1];
   assign D        = cmd_s[2];
   assign R        = cmd_s[3];
   assign game_rst = game_rst_r;
   assign score    = score_r;
   assign level    = level_r;
   assign running  = running_r;

endmodule
